// File: rtl/cool_heat_pkg.sv
// Shared definitions for the temperature-driven fan controller: state encoding,
// default hysteresis thresholds and the cooling speed tier table.
package cool_heat_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COOLING = 2'd1,
      ST_HEATING = 2'd2
   } state_t;

   localparam int unsigned DEF_COOL_ON  = 35;
   localparam int unsigned DEF_COOL_OFF = 25;
   localparam int unsigned DEF_HEAT_ON  = 15;
   localparam int unsigned DEF_HEAT_OFF = 30;
   localparam int unsigned DEF_STEP     = 16;
   localparam int unsigned DEF_RAMP_DIV = 256;

   // Lower bounds (inclusive) of the 2nd, 3rd and 4th cooling tiers.
   localparam logic [7:0] TIER_LO  = 8'd35;
   localparam logic [7:0] TIER_MID = 8'd40;
   localparam logic [7:0] TIER_HI  = 8'd45;

   localparam logic [7:0] SPD_T0   = 8'd64;
   localparam logic [7:0] SPD_T1   = 8'd128;
   localparam logic [7:0] SPD_T2   = 8'd192;
   localparam logic [7:0] SPD_T3   = 8'd255;
   localparam logic [7:0] SPD_HEAT = 8'd128;

   function automatic logic [7:0] target_speed(input state_t st, input logic [7:0] t);
      logic [7:0] spd;
      spd = '0;
      case (st)
         ST_COOLING: begin
            if (t < TIER_LO)       spd = SPD_T0;
            else if (t < TIER_MID) spd = SPD_T1;
            else if (t < TIER_HI)  spd = SPD_T2;
            else                   spd = SPD_T3;
         end
         ST_HEATING: spd = SPD_HEAT;
         default:    spd = '0;
      endcase
      return spd;
   endfunction

endpackage

// File: rtl/speed_slew.sv
// Slew limiter for the fan duty: a free-running tick counter and a ramp that
// moves speed toward the target by at most STEP per tick.
module speed_slew
   import cool_heat_pkg::*;
#(
   parameter int unsigned STEP     = DEF_STEP,
   parameter int unsigned RAMP_DIV = DEF_RAMP_DIV
) (
   input  logic       clk,
   input  logic       arst,
   input  logic [7:0] target_i,
   output logic [7:0] speed_o
);

   localparam int unsigned     CW       = $clog2(RAMP_DIV);
   localparam logic [CW-1:0]   CNT_LAST = CW'(RAMP_DIV - 1);
   localparam logic [8:0]      STEP9    = 9'(STEP);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick;
   logic [7:0]    speed_q, speed_d;
   logic [8:0]    tgt9, spd9, diff9;

   always_comb begin
      tick    = (cnt_q == CNT_LAST);
      cnt_d   = tick ? '0 : cnt_q + CW'(1);
      tgt9    = {1'b0, target_i};
      spd9    = {1'b0, speed_q};
      diff9   = (tgt9 >= spd9) ? (tgt9 - spd9) : (spd9 - tgt9);
      speed_d = speed_q;
      // Snapping to target when within STEP keeps the 9-bit sums inside 0..255.
      if (tick) begin
         if (diff9 <= STEP9)   speed_d = target_i;
         else if (tgt9 > spd9) speed_d = 8'(spd9 + STEP9);
         else                  speed_d = 8'(spd9 - STEP9);
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         cnt_q   <= '0;
         speed_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         speed_q <= speed_d;
      end
   end

   assign speed_o = speed_q;

endmodule

// File: rtl/temp_fan_controller.sv
// Hysteretic IDLE/COOLING/HEATING controller: latches sampled temperature,
// maps state and temperature to a fan target and slews the fan duty toward it.
module temp_fan_controller
   import cool_heat_pkg::*;
#(
   parameter int unsigned COOL_ON  = DEF_COOL_ON,
   parameter int unsigned COOL_OFF = DEF_COOL_OFF,
   parameter int unsigned HEAT_ON  = DEF_HEAT_ON,
   parameter int unsigned HEAT_OFF = DEF_HEAT_OFF,
   parameter int unsigned STEP     = DEF_STEP,
   parameter int unsigned RAMP_DIV = DEF_RAMP_DIV
) (
   input  logic       clk,
   input  logic       arst,
   input  logic       temp_valid,
   input  logic [7:0] temp,
   output logic       cooler_on,
   output logic       heater_on,
   output logic [7:0] speed,
   output logic [1:0] mode
);

   localparam logic [7:0] COOL_ON_T  = 8'(COOL_ON);
   localparam logic [7:0] COOL_OFF_T = 8'(COOL_OFF);
   localparam logic [7:0] HEAT_ON_T  = 8'(HEAT_ON);
   localparam logic [7:0] HEAT_OFF_T = 8'(HEAT_OFF);

   state_t     state_q, state_d;
   logic [7:0] temp_q;
   logic       cooler_q, heater_q;
   logic [7:0] target;

   // No COOLING<->HEATING arcs: every mode change goes through IDLE.
   always_comb begin
      state_d = state_q;
      if (temp_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (temp > COOL_ON_T)      state_d = ST_COOLING;
               else if (temp < HEAT_ON_T) state_d = ST_HEATING;
            end
            ST_COOLING: if (temp < COOL_OFF_T) state_d = ST_IDLE;
            ST_HEATING: if (temp > HEAT_OFF_T) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q  <= ST_IDLE;
         temp_q   <= '0;
         cooler_q <= 1'b0;
         heater_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cooler_q <= (state_d == ST_COOLING);
         heater_q <= (state_d == ST_HEATING);
         if (temp_valid) temp_q <= temp;
      end
   end

   assign target = target_speed(state_q, temp_q);

   speed_slew #(
      .STEP     (STEP),
      .RAMP_DIV (RAMP_DIV)
   ) u_slew (
      .clk      (clk),
      .arst     (arst),
      .target_i (target),
      .speed_o  (speed)
   );

   assign cooler_on = cooler_q;
   assign heater_on = heater_q;
   assign mode      = state_q;

   cooler_heater_exclusive: assert property (@(posedge clk) disable iff (!arst)
      !(cooler_q && heater_q));

endmodule

// File: tb/tb_temp_fan_controller.sv
// Scoreboard bench: stimulus queues expected output snapshots, a monitor pops
// and compares whenever the outputs change or a hold check is requested.
module tb_temp_fan_controller;

   localparam int unsigned P_COOL_ON  = 35;
   localparam int unsigned P_COOL_OFF = 25;
   localparam int unsigned P_HEAT_ON  = 15;
   localparam int unsigned P_HEAT_OFF = 30;
   localparam int unsigned P_STEP     = 16;
   localparam int unsigned P_RAMP_DIV = 4;

   if (!(P_HEAT_ON < P_COOL_OFF && P_COOL_OFF <= P_COOL_ON && P_HEAT_OFF <= P_COOL_ON))
   begin : g_bad_thresholds
      $fatal(1, "threshold ordering violated");
   end

   logic       clk = 1'b0;
   logic       arst = 1'b0;
   logic       temp_valid = 1'b0;
   logic [7:0] temp = '0;
   logic       cooler_on, heater_on;
   logic [7:0] speed;
   logic [1:0] mode;

   temp_fan_controller #(
      .COOL_ON  (P_COOL_ON),
      .COOL_OFF (P_COOL_OFF),
      .HEAT_ON  (P_HEAT_ON),
      .HEAT_OFF (P_HEAT_OFF),
      .STEP     (P_STEP),
      .RAMP_DIV (P_RAMP_DIV)
   ) dut (
      .clk        (clk),
      .arst       (arst),
      .temp_valid (temp_valid),
      .temp       (temp),
      .cooler_on  (cooler_on),
      .heater_on  (heater_on),
      .speed      (speed),
      .mode       (mode)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [1:0] mode;
      logic       cooler;
      logic       heater;
      logic [7:0] speed;
   } snap_t;

   typedef struct {
      snap_t s;
      int    dl;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic chk_req = 1'b0;
   logic mon_en = 1'b0;

   function automatic snap_t cur_snap();
      snap_t s;
      s = {mode, cooler_on, heater_on, speed};
      return s;
   endfunction

   task automatic push(input logic [1:0] m, input logic c, input logic h,
                       input logic [7:0] s, input int dl);
      exp_t e;
      e.s  = {m, c, h, s};
      e.dl = dl;
      exp_q.push_back(e);
   endtask

   // Expected speed sequence for a ramp from 'from' to 'to' with step P_STEP.
   task automatic ramp(input logic [1:0] m, input logic c, input logic h,
                       input int from, input int to);
      int spd;
      spd = from;
      while (spd != to) begin
         if (to > spd) spd = (to - spd <= int'(P_STEP)) ? to : spd + int'(P_STEP);
         else          spd = (spd - to <= int'(P_STEP)) ? to : spd - int'(P_STEP);
         push(m, c, h, 8'(spd), -1);
      end
   endtask

   // One-cycle temp_valid strobe; a mode change must show one cycle later.
   task automatic pulse(input logic [7:0] t, input bit chg, input logic [1:0] m,
                        input logic c, input logic h, input logic [7:0] s);
      @(posedge clk);
      #1;
      temp       = t;
      temp_valid = 1'b1;
      if (chg) push(m, c, h, s, cyc + 1);
      @(posedge clk);
      #1;
      temp_valid = 1'b0;
   endtask

   task automatic drain(input string what);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s: %0d expected snapshots still pending, want 0", what, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic hold(input logic [1:0] m, input logic c, input logic h, input logic [7:0] s);
      repeat (12) @(posedge clk);
      #1;
      push(m, c, h, s, -1);
      chk_req = 1'b1;
      @(negedge clk);
      #2;
      chk_req = 1'b0;
   endtask

   initial begin : monitor
      snap_t last, cur;
      exp_t  e;
      int    last_spd_cyc;
      bit    spd_valid;
      spd_valid    = 1'b0;
      last_spd_cyc = 0;
      wait (mon_en);
      last = cur_snap();
      forever begin
         @(negedge clk or negedge arst);
         #1;
         cur = cur_snap();
         if (cur != last || chk_req) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_output: got mode=%0d cooler=%0b heater=%0b speed=%0d, want no change",
                        cur.mode, cur.cooler, cur.heater, cur.speed);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e.s) begin
                  miscompares++;
                  $display("FAIL snapshot: got mode=%0d cooler=%0b heater=%0b speed=%0d, want mode=%0d cooler=%0b heater=%0b speed=%0d",
                           cur.mode, cur.cooler, cur.heater, cur.speed,
                           e.s.mode, e.s.cooler, e.s.heater, e.s.speed);
               end
               if (e.dl >= 0) begin
                  vectors++;
                  if (cyc != e.dl) begin
                     miscompares++;
                     $display("FAIL mode_latency: got cycle %0d, want cycle %0d", cyc, e.dl);
                  end
               end
            end
            if (!arst) begin
               spd_valid = 1'b0;
            end else if (cur.speed != last.speed) begin
               if (spd_valid) begin
                  vectors++;
                  if ((cyc - last_spd_cyc) % int'(P_RAMP_DIV) != 0) begin
                     miscompares++;
                     $display("FAIL tick_spacing: got %0d cycles between steps, want multiple of %0d",
                              cyc - last_spd_cyc, P_RAMP_DIV);
                  end
               end
               spd_valid    = 1'b1;
               last_spd_cyc = cyc;
            end
            last = cur;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      repeat (3) @(posedge clk);
      #1;
      arst   = 1'b1;
      mon_en = 1'b1;
      hold(2'd0, 1'b0, 1'b0, 8'd0);

      // IDLE -> COOLING, tier 40..44 -> 192
      pulse(8'd40, 1'b1, 2'd1, 1'b1, 1'b0, 8'd0);
      ramp(2'd1, 1'b1, 1'b0, 0, 192);
      drain("ramp_to_192");
      hold(2'd1, 1'b1, 1'b0, 8'd192);

      // 30 keeps COOLING (not below 25), tier <35 -> 64
      pulse(8'd30, 1'b0, 2'd1, 1'b1, 1'b0, 8'd192);
      ramp(2'd1, 1'b1, 1'b0, 192, 64);
      drain("ramp_to_64");
      hold(2'd1, 1'b1, 1'b0, 8'd64);

      pulse(8'd24, 1'b1, 2'd0, 1'b0, 1'b0, 8'd64);
      ramp(2'd0, 1'b0, 1'b0, 64, 0);
      drain("cool_off_ramp");
      hold(2'd0, 1'b0, 1'b0, 8'd0);

      // Threshold boundaries from IDLE
      pulse(8'd35, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
      hold(2'd0, 1'b0, 1'b0, 8'd0);
      pulse(8'd15, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
      hold(2'd0, 1'b0, 1'b0, 8'd0);
      pulse(8'd14, 1'b1, 2'd2, 1'b0, 1'b1, 8'd0);
      ramp(2'd2, 1'b0, 1'b1, 0, 128);
      drain("heat_ramp");
      hold(2'd2, 1'b0, 1'b1, 8'd128);
      pulse(8'd30, 1'b0, 2'd2, 1'b0, 1'b1, 8'd128);
      hold(2'd2, 1'b0, 1'b1, 8'd128);
      pulse(8'd31, 1'b1, 2'd0, 1'b0, 1'b0, 8'd128);
      ramp(2'd0, 1'b0, 1'b0, 128, 0);
      drain("heat_off_ramp");
      hold(2'd0, 1'b0, 1'b0, 8'd0);

      // Top tier: 240 -> 255 is a step of 15
      pulse(8'd50, 1'b1, 2'd1, 1'b1, 1'b0, 8'd0);
      ramp(2'd1, 1'b1, 1'b0, 0, 255);
      drain("ramp_to_255");
      hold(2'd1, 1'b1, 1'b0, 8'd255);

      // temp wiggles without temp_valid must be ignored
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         temp = 8'(i * 27 + 3);
      end
      hold(2'd1, 1'b1, 1'b0, 8'd255);

      // Tier edges on the way down
      pulse(8'd44, 1'b0, 2'd1, 1'b1, 1'b0, 8'd255);
      ramp(2'd1, 1'b1, 1'b0, 255, 192);
      drain("tier_44");
      hold(2'd1, 1'b1, 1'b0, 8'd192);
      pulse(8'd39, 1'b0, 2'd1, 1'b1, 1'b0, 8'd192);
      ramp(2'd1, 1'b1, 1'b0, 192, 128);
      drain("tier_39");
      hold(2'd1, 1'b1, 1'b0, 8'd128);
      pulse(8'd35, 1'b0, 2'd1, 1'b1, 1'b0, 8'd128);
      hold(2'd1, 1'b1, 1'b0, 8'd128);
      pulse(8'd34, 1'b0, 2'd1, 1'b1, 1'b0, 8'd128);
      ramp(2'd1, 1'b1, 1'b0, 128, 64);
      drain("tier_34");
      hold(2'd1, 1'b1, 1'b0, 8'd64);

      // Asynchronous reset mid-ramp, between clock edges
      pulse(8'd50, 1'b0, 2'd1, 1'b1, 1'b0, 8'd64);
      push(2'd1, 1'b1, 1'b0, 8'd80, -1);
      push(2'd1, 1'b1, 1'b0, 8'd96, -1);
      push(2'd1, 1'b1, 1'b0, 8'd112, -1);
      drain("pre_reset_ramp");
      push(2'd0, 1'b0, 1'b0, 8'd0, -1);
      arst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      arst = 1'b1;
      drain("async_reset");
      hold(2'd0, 1'b0, 1'b0, 8'd0);

      pulse(8'd50, 1'b1, 2'd1, 1'b1, 1'b0, 8'd0);
      ramp(2'd1, 1'b1, 1'b0, 0, 255);
      drain("post_reset_ramp");
      hold(2'd1, 1'b1, 1'b0, 8'd255);

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/temp_fan_controller.md
TEMP_FAN_CONTROLLER -- requirements
Module: temp_fan_controller

Interface
REQ-001 Parameter COOL_ON, 35: IDLE->COOLING threshold, strict greater-than.
REQ-002 Parameter COOL_OFF, 25: COOLING->IDLE threshold, strict less-than.
REQ-003 Parameter HEAT_ON, 15: IDLE->HEATING threshold, strict less-than.
REQ-004 Parameter HEAT_OFF, 30: HEATING->IDLE threshold, strict greater-than.
REQ-005 Parameter STEP, 16: maximum speed change per ramp tick (1..255).
REQ-006 Parameter RAMP_DIV, 256: clocks per ramp tick (>=2).
REQ-007 clk  in  1  clock, rising edge.
REQ-008 arst  in  1  reset, asynchronous, active-low.
REQ-009 temp_valid  in  1  single-cycle strobe; temp is sampled only when high.
REQ-010 temp  in  8  unsigned sensor temperature, degrees C.
REQ-011 cooler_on  out  1  cooler enable.
REQ-012 heater_on  out  1  heater enable.
REQ-013 speed  out  8  fan duty, 0..255; this is the speed input of the downstream PWM stage.
REQ-014 mode  out  2  current state: 0 IDLE, 1 COOLING, 2 HEATING.

Function
REQ-015 States are IDLE, COOLING and HEATING; transitions are evaluated only in cycles where temp_valid=1.
REQ-016 IDLE: temp>COOL_ON -> COOLING; else temp<HEAT_ON -> HEATING; else stay in IDLE.
REQ-017 COOLING: temp<COOL_OFF -> IDLE; otherwise stay. HEATING: temp>HEAT_OFF -> IDLE; otherwise stay.
REQ-018 There are no direct COOLING<->HEATING transitions; each mode change passes through IDLE for at least one sample.
REQ-019 On a temp_valid edge, temp_q latches temp and state updates; mode, cooler_on and heater_on are registered and reflect the new state from the next cycle.
REQ-020 cooler_on=1 only in COOLING and heater_on=1 only in HEATING; both high is illegal and never occurs.
REQ-021 Target speed is a combinational function of state and temp_q: IDLE 0; HEATING 128; COOLING temp_q<35 -> 64, 35..39 -> 128, 40..44 -> 192, >=45 -> 255.
REQ-022 A free-running tick counter counts 0..RAMP_DIV-1 from reset and wraps; a ramp tick occurs in the cycle the counter equals RAMP_DIV-1.
REQ-023 On a ramp tick: if |target-speed|<=STEP then speed=target; otherwise speed moves toward target by STEP.
REQ-024 Ramp arithmetic uses 9 bits; speed never overflows, underflows or overshoots the target.
REQ-025 When the target changes mid-ramp, ramping continues from the current speed toward the new target; speed never jumps.
REQ-026 Between ticks, speed holds its value.
REQ-027 Changes on temp without temp_valid have no effect on any output.

Reset
REQ-028 When arst=0, the block immediately clears state to IDLE, and temp_q, speed, the tick counter, cooler_on, heater_on and mode to 0, regardless of clk.
REQ-029 Reset asserted mid-ramp or mid-mode aborts the operation; after release, operation resumes from the IDLE/0 condition.

Structure
REQ-030 A shared package (cool_heat_pkg) holds the state encoding, the tier boundaries and values (35/40/45; 64/128/192/255) and the default thresholds.
REQ-031 The slew limiter (tick counter plus ramp logic, REQ-022..026) is one sub-module named speed_slew; the FSM, temp latch and target mapping stay in the top module.
REQ-032 Parameters are required to satisfy HEAT_ON<COOL_OFF<=COOL_ON and HEAT_OFF<=COOL_ON; the bench checks this at elaboration.

Verification (bench: RAMP_DIV=4, STEP=16)
REQ-033 Pulse temp=40 with temp_valid -> mode=1 and cooler_on=1 next cycle; speed climbs 16,32,...,192, one step per 4 clocks, reaching 192 after 12 ticks and holding.
REQ-034 From COOLING, temp=30 -> stays COOLING, speed ramps to 64; then temp=24 -> IDLE, cooler_on=0, speed ramps down to 0.
REQ-035 In IDLE: temp=35 -> stays IDLE; temp=15 -> stays IDLE; temp=14 -> HEATING, heater_on=1, speed ramps to 128; temp=30 -> stays HEATING; temp=31 -> IDLE.
REQ-036 From COOLING at speed 240 with temp_q>=45 -> next tick gives speed 255 (step of 15, no overshoot).
REQ-037 Toggle temp with temp_valid=0 -> all outputs unchanged.
REQ-038 Assert arst=0 mid-ramp between clock edges -> speed, cooler_on, heater_on and mode go to 0 at once; after release, temp=50 -> ramp restarts from 0.
